// File: rtl/div_ratio_sequencer_if.sv
// Requester/divider-side bundle of the divide-ratio sequencer.
// master = requesters (plus freeze control), slave = the sequencer itself.
interface div_ratio_sequencer_if #(
    parameter int REQ_NUM   = 2,
    parameter int STAGE_NUM = 4
);
    localparam int LW = $clog2(STAGE_NUM + 1);
    localparam int SW = $clog2(STAGE_NUM) + 1;

    logic [REQ_NUM-1:0]    req;
    logic [REQ_NUM*LW-1:0] req_level;
    logic                  freeze;
    logic [REQ_NUM-1:0]    ack;
    logic                  busy;
    logic [LW-1:0]         cur_level;
    logic [SW-1:0]         div_sel;

    modport master (
        output req, req_level, freeze,
        input  ack, busy, cur_level, div_sel
    );

    modport slave (
        input  req, req_level, freeze,
        output ack, busy, cur_level, div_sel
    );
endinterface

// File: rtl/div_ratio_sequencer.sv
// Round-robin owner of the glitch-free divider's div_sel: ramps one
// power-of-two level per step and holds a settle window after every change.
module div_ratio_sequencer #(
    parameter int REQ_NUM       = 2,
    parameter int STAGE_NUM     = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESET_LEVEL   = 0
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    div_ratio_sequencer_if.slave   bus
);
    localparam int LW = $clog2(STAGE_NUM + 1);
    localparam int SW = $clog2(STAGE_NUM) + 1;
    localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int KW = IW + 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [LW-1:0]      MAX_LVL = LW'(STAGE_NUM);
    localparam logic [LW-1:0]      RST_LVL = LW'(RESET_LEVEL);
    localparam logic [REQ_NUM-1:0] ONE_HOT = REQ_NUM'(1);

    typedef enum logic [1:0] {IDLE, STEP, SETTLE, DONE} state_t;

    // Level 0 bypasses the divider; level k selects stage k-1 with the enable MSB set.
    function automatic logic [SW-1:0] enc(input logic [LW-1:0] lvl);
        logic [SW-1:0] r;
        r = '0;
        if (lvl != '0) begin
            r         = SW'(lvl - 1'b1);
            r[SW-1]   = 1'b1;
        end
        return r;
    endfunction

    state_t                     state;
    logic [IW-1:0]              rr;
    logic [IW-1:0]              gnt;
    logic [LW-1:0]              tgt;
    logic [CW-1:0]              cnt;
    logic [LW-1:0]              cur_level;
    logic [SW-1:0]              div_sel;
    logic [REQ_NUM-1:0]         ack;
    logic                       busy;

    logic [REQ_NUM-1:0][LW-1:0] tgt_clamp;
    logic                       gnt_vld;
    logic [IW-1:0]              gnt_idx;
    logic [LW-1:0]              step_level;

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_clamp
        assign tgt_clamp[i] = (bus.req_level[i*LW +: LW] > MAX_LVL) ?
                              MAX_LVL : bus.req_level[i*LW +: LW];
    end

    // Scan downward so the requester closest to rr (offset 0) is written last and wins.
    always_comb begin
        logic [KW-1:0] ks;
        logic [IW-1:0] k;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        ks      = '0;
        k       = '0;
        for (int j = REQ_NUM - 1; j >= 0; j--) begin
            ks = {1'b0, rr} + KW'(j);
            if (ks >= KW'(REQ_NUM))
                ks = ks - KW'(REQ_NUM);
            k = ks[IW-1:0];
            if (bus.req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = k;
            end
        end
    end

    assign step_level = (tgt > cur_level) ? cur_level + 1'b1 : cur_level - 1'b1;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= '0;
            gnt       <= '0;
            tgt       <= '0;
            cnt       <= '0;
            cur_level <= RST_LVL;
            div_sel   <= enc(RST_LVL);
            ack       <= '0;
            busy      <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (!bus.freeze && gnt_vld) begin
                        gnt  <= gnt_idx;
                        tgt  <= tgt_clamp[gnt_idx];
                        rr   <= (gnt_idx == IW'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
                        busy <= 1'b1;
                        if (tgt_clamp[gnt_idx] != cur_level) begin
                            state <= STEP;
                        end else begin
                            state <= DONE;
                            ack   <= ONE_HOT << gnt_idx;
                        end
                    end
                end
                STEP: begin
                    cur_level <= step_level;
                    div_sel   <= enc(step_level);
                    cnt       <= CW'(SETTLE_CYCLES - 1);
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (cur_level == tgt) begin
                        state <= DONE;
                        ack   <= ONE_HOT << gnt;
                    end else begin
                        state <= STEP;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack;
    assign bus.busy      = busy;
    assign bus.cur_level = cur_level;
    assign bus.div_sel   = div_sel;
endmodule

// File: tb/tb_div_ratio_sequencer.sv
// Bench for div_ratio_sequencer: table of single requests, contention, freeze
// and reset-mid-ramp sequences, with an ack scoreboard and div_sel spacing monitor.
module tb_div_ratio_sequencer;
    localparam int REQ_NUM = 2;
    localparam int STAGE_NUM = 4;
    localparam int SETTLE = 8;
    localparam int LW = 3;
    localparam int SW = 3;
    localparam int GAP = SETTLE + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;

    div_ratio_sequencer_if #(.REQ_NUM(REQ_NUM), .STAGE_NUM(STAGE_NUM)) bus();

    div_ratio_sequencer #(
        .REQ_NUM(REQ_NUM), .STAGE_NUM(STAGE_NUM),
        .SETTLE_CYCLES(SETTLE), .RESET_LEVEL(0)
    ) dut (
        .clk_in(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int lvl;
        int exp_lvl;
        int d;
        int mode;   // 0 plain, 1 freeze before grant, 2 freeze raised mid-ramp
    } vec_t;

    typedef struct {
        int idx;
        int lvl;
        int ack_cyc;  // -1: latency not checked
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   chg_cyc[$];
    int   chg_lvl[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ack_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int enc_tb(input int k);
        return (k == 0) ? 0 : (1 << (SW - 1)) + k - 1;
    endfunction

    // Monitor: div_sel change spacing and encoding, ack shape, scoreboard pops.
    int prev_ds = 0;
    int prev_ack = 0;
    int last_chg = -1;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ds  = int'(bus.div_sel);
            prev_ack = 0;
            last_chg = -1;
        end else begin
            if (int'(bus.div_sel) != prev_ds) begin
                chk("div_sel_enc", int'(bus.div_sel), enc_tb(int'(bus.cur_level)));
                if (last_chg >= 0) chk("chg_spacing_ge_gap", int'(cyc - last_chg >= GAP), 1);
                last_chg = cyc;
                chg_cyc.push_back(cyc);
                chg_lvl.push_back(int'(bus.cur_level));
                prev_ds = int'(bus.div_sel);
            end
            if (bus.ack != '0) begin
                chk("ack_onehot", $countones(bus.ack), 1);
                chk("ack_single_cycle", prev_ack, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", int'(bus.ack), 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_idx", int'(bus.ack), 1 << e.idx);
                    chk("ack_level", int'(bus.cur_level), e.lvl);
                    chk("ack_div_sel", int'(bus.div_sel), enc_tb(e.lvl));
                    if (e.ack_cyc >= 0) chk("ack_latency", cyc, e.ack_cyc);
                end
                ack_seen++;
            end
            prev_ack = int'(bus.ack);
        end
    end

    task automatic wait_ack(input int target, input int budget);
        int n = 0;
        while (ack_seen < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ack_within_budget", int'(ack_seen >= target), 1);
    endtask

    task automatic do_req(input int idx, input int lvl, input int exp_lvl, input int d, input int mode);
        int   start;
        int   base;
        int   busy_seen;
        exp_t e;
        @(posedge clk); #1;
        chg_cyc.delete();
        chg_lvl.delete();
        base = int'(bus.cur_level);
        bus.req_level[idx*LW +: LW] = LW'(lvl);
        bus.req[idx] = 1'b1;
        if (mode == 1) begin
            bus.freeze = 1'b1;
            busy_seen = 0;
            repeat (15) begin
                @(negedge clk);
                busy_seen |= int'(bus.busy);
            end
            chk("freeze_blocks_grant", busy_seen, 0);
            @(posedge clk); #1;
            bus.freeze = 1'b0;
        end
        start = cyc;
        e.idx = idx; e.lvl = exp_lvl; e.ack_cyc = start + 1 + d * GAP;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("busy_after_grant", int'(bus.busy), 1);
        if (mode == 2) begin
            repeat (5) @(negedge clk);
            bus.freeze = 1'b1;
        end
        wait_ack(ack_seen + 1, d * GAP + 30);
        bus.req[idx] = 1'b0;
        bus.freeze = 1'b0;
        chk("n_changes", chg_cyc.size(), d);
        for (int j = 0; j < chg_cyc.size() && j < d; j++) begin
            chk("chg_edge", chg_cyc[j], start + 2 + j * GAP);
            chk("chg_level", chg_lvl[j], (exp_lvl > base) ? base + j + 1 : base - j - 1);
        end
        @(posedge clk); #1;
        chk("busy_fall", int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   start;
        exp_t e;
        // level targets, clamps, zero distance and freeze variants (start level 0)
        vecs[0] = '{idx: 0, lvl: 3, exp_lvl: 3, d: 3, mode: 0};
        vecs[1] = '{idx: 1, lvl: 7, exp_lvl: 4, d: 1, mode: 0};
        vecs[2] = '{idx: 0, lvl: 0, exp_lvl: 0, d: 4, mode: 0};
        vecs[3] = '{idx: 1, lvl: 2, exp_lvl: 2, d: 2, mode: 1};
        vecs[4] = '{idx: 0, lvl: 2, exp_lvl: 2, d: 0, mode: 0};
        vecs[5] = '{idx: 1, lvl: 5, exp_lvl: 4, d: 2, mode: 2};
        vecs[6] = '{idx: 0, lvl: 1, exp_lvl: 1, d: 3, mode: 0};

        bus.req = '0;
        bus.req_level = '0;
        bus.freeze = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_div_sel", int'(bus.div_sel), 0);
        chk("rst_cur_level", int'(bus.cur_level), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ack", int'(bus.ack), 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;

        repeat (20) @(posedge clk);
        #1;
        chk("idle_div_sel", int'(bus.div_sel), 0);
        chk("idle_cur_level", int'(bus.cur_level), 0);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_no_changes", chg_cyc.size(), 0);

        for (int v = 0; v < 7; v++)
            do_req(vecs[v].idx, vecs[v].lvl, vecs[v].exp_lvl, vecs[v].d, vecs[v].mode);

        // Contention: both held; rr is 1 after the last table grant (idx 0).
        @(posedge clk); #1;
        bus.req_level[0*LW +: LW] = 3'd2;
        bus.req_level[1*LW +: LW] = 3'd4;
        bus.req = 2'b11;
        start = cyc;
        e.idx = 1; e.lvl = 4; e.ack_cyc = start + 1 + 3 * GAP;        sb.push_back(e);
        e.idx = 0; e.lvl = 2; e.ack_cyc = e.ack_cyc + 2 + 2 * GAP;    sb.push_back(e);
        e.idx = 1; e.lvl = 4; e.ack_cyc = e.ack_cyc + 2 + 2 * GAP;    sb.push_back(e);
        e.idx = 0; e.lvl = 2; e.ack_cyc = e.ack_cyc + 2 + 2 * GAP;    sb.push_back(e);
        wait_ack(ack_seen + 4, 200);
        bus.req = 2'b00;
        chk("contention_sb_drained", sb.size(), 0);

        // Reset mid-ramp: bring level to 0, then interrupt a 0->4 ramp granted to idx 0.
        do_req(1, 0, 0, 2, 0);
        @(posedge clk); #1;
        bus.req_level[0*LW +: LW] = 3'd4;
        bus.req[0] = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("pre_reset_level", int'(bus.cur_level), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midramp_rst_div_sel", int'(bus.div_sel), 0);
        chk("midramp_rst_cur_level", int'(bus.cur_level), 0);
        chk("midramp_rst_busy", int'(bus.busy), 0);
        chk("midramp_rst_ack", int'(bus.ack), 0);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // rr must be back at 0: simultaneous requests grant idx 0 first.
        @(posedge clk); #1;
        bus.req_level[0*LW +: LW] = 3'd3;
        bus.req_level[1*LW +: LW] = 3'd1;
        bus.req = 2'b11;
        start = cyc;
        e.idx = 0; e.lvl = 3; e.ack_cyc = start + 1 + 3 * GAP;
        sb.push_back(e);
        wait_ack(ack_seen + 1, 60);
        bus.req = 2'b00;

        repeat (30) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);
        chk("final_busy", int'(bus.busy), 0);
        chk("final_level", int'(bus.cur_level), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
